// File: rtl/cos_pkg.sv
// Shared definitions for the cosine job driver: default widths, watchdog limit
// and the FSM state encoding.
package cos_pkg;

    localparam int XW_DEF      = 8;
    localparam int RW_DEF      = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_ACK   = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_OUT   = 3'd4;

endpackage

// File: rtl/cos_watchdog.sv
// Cycle watchdog for the job driver: counts while enabled, flags expiry at
// TIMEOUT-1. Only instantiated when COS_TIMEOUT_EN is defined.
module cos_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // Saturate at the limit so expired stays asserted until the driver reacts
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cos_job_driver.sv
// Sequences angle jobs into an external cosine engine and returns tagged results.
// Optional watchdog enabled by defining COS_TIMEOUT_EN.
module cos_job_driver
    import cos_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    output logic          in_ready,
    output logic          eng_start,
    output logic [XW-1:0] eng_x,
    input  logic          eng_done,
    input  logic [RW-1:0] eng_result,
    output logic          out_valid,
    output logic [RW-1:0] out_result,
    output logic [7:0]    out_tag,
    output logic          out_err,
    input  logic          out_ready,
    output logic          busy
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] job_cnt;
    logic       timed_out;

`ifdef COS_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    cos_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_START && eng_done),
        .enable  (state == ST_ACK || state == ST_RUN),
        .expired (wd_expired)
    );

    // A completing engine wins over the watchdog on the same RUN cycle
    assign timed_out = wd_expired &&
                       (state == ST_ACK || (state == ST_RUN && !eng_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_RUN && eng_done) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign out_err = err_q;
`else
    assign timed_out = 1'b0;
    assign out_err   = 1'b0;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign eng_start = (state == ST_START) && eng_done;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_START;
            ST_START: if (eng_done) state_nxt = ST_ACK;
            ST_ACK: begin
                if (timed_out)      state_nxt = ST_OUT;
                else if (!eng_done) state_nxt = ST_RUN;
            end
            ST_RUN:   if (eng_done || timed_out) state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // OUT always returns through IDLE, so a request waiting at out_ready is taken a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            job_cnt    <= '0;
            out_tag    <= '0;
            eng_x      <= '0;
            out_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && in_valid) begin
                eng_x   <= in_x;
                out_tag <= job_cnt;
                job_cnt <= job_cnt + 8'd1;
            end
            if (state == ST_RUN && eng_done) begin
                out_result <= eng_result;
            end else if (timed_out) begin
                out_result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cos_job_driver.sv
// Self-checking bench for cos_job_driver: per-cycle vector table plus directed
// multi-cycle sequences (stall, back-to-back, mid-job reset, watchdog).
module tb_cos_job_driver;
    import cos_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_x;
    logic        in_ready;
    logic        eng_start;
    logic [7:0]  eng_x;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        out_valid;
    logic [15:0] out_result;
    logic [7:0]  out_tag;
    logic        out_err;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cos_job_driver #(
        .XW      (8),
        .RW      (16),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_ready   (in_ready),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  ix;
        logic        ed;
        logic [15:0] er;
        logic        ordy;
        logic        ir;
        logic        bsy;
        logic        es;
        logic        ov;
        logic [15:0] res;
        logic [7:0]  tag;
        logic        err;
        logic [7:0]  ex;
    } vec_t;

    // Drive inputs just after the rising edge, then settle to mid-cycle for sampling
    task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] ix,
                                 input logic ed, input logic [15:0] er, input logic ordy);
        @(posedge clk);
        #1;
        rst        = r;
        in_valid   = iv;
        in_x       = ix;
        eng_done   = ed;
        eng_result = er;
        out_ready  = ordy;
        #4;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
    endtask

    vec_t tbl [15];

    initial begin
        int starts;
        int since;
        int first;
        logic [15:0] jres;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; eng_done = 1'b1;
        eng_result = '0; out_ready = 1'b0;

        //         rst   iv    ix     ed    er        ordy | ir    bsy   es    ov    res       tag    err   ex
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h20, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h7F00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h20};
        tbl[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7F00, 8'h00, 1'b0, 8'h20};
        tbl[8]  = '{1'b0, 1'b1, 8'h55, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7F00, 8'h00, 1'b0, 8'h20};
        tbl[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7F00, 8'h00, 1'b0, 8'h20};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7F00, 8'h01, 1'b0, 8'h55};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7F00, 8'h01, 1'b0, 8'h55};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7F00, 8'h01, 1'b0, 8'h55};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h01, 1'b0, 8'h55};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h01, 1'b0, 8'h55};

        $display("[TB] reset and vector table");
        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].iv, tbl[i].ix, tbl[i].ed, tbl[i].er, tbl[i].ordy);
            checkOutput($sformatf("v%0d in_ready", i),   in_ready,   tbl[i].ir);
            checkOutput($sformatf("v%0d busy", i),       busy,       tbl[i].bsy);
            checkOutput($sformatf("v%0d eng_start", i),  eng_start,  tbl[i].es);
            checkOutput($sformatf("v%0d out_valid", i),  out_valid,  tbl[i].ov);
            checkOutput($sformatf("v%0d out_result", i), out_result, tbl[i].res);
            checkOutput($sformatf("v%0d out_tag", i),    out_tag,    tbl[i].tag);
            checkOutput($sformatf("v%0d out_err", i),    out_err,    tbl[i].err);
            checkOutput($sformatf("v%0d eng_x", i),      eng_x,      tbl[i].ex);
        end

        $display("[TB] reset during RUN");
        applyStimulus(1'b0, 1'b1, 8'h66, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("rstrun pre busy", busy, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b0);
        checkOutput("rstrun busy", busy, 1'b0);
        checkOutput("rstrun in_ready", in_ready, 1'b1);
        checkOutput("rstrun out_valid", out_valid, 1'b0);
        checkOutput("rstrun out_result", out_result, 16'h0000);
        checkOutput("rstrun out_tag", out_tag, 8'h00);
        checkOutput("rstrun eng_x", eng_x, 8'h00);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b1);
            checkOutput($sformatf("rstrun stale out_valid c%0d", k), out_valid, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        checkOutput("rstrun new tag", out_tag, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0101, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("rstrun new out_valid", out_valid, 1'b1);
        checkOutput("rstrun new out_result", out_result, 16'h0101);

        $display("[TB] single job with slow engine");
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h20, 1'b1, 16'h7F00, 1'b0);
        starts = 0; since = -1; first = -1;
        for (int c = 0; c < 60 && first < 0; c++) begin
            if (since >= 0) since++;
            applyStimulus(1'b0, 1'b0, 8'h00,
                          (since < 0 || since == 1 || since >= 11) ? 1'b1 : 1'b0,
                          16'h7F00, 1'b0);
            if (eng_start) begin
                starts++;
                if (since < 0) since = 0;
            end
            if (out_valid) first = c;
        end
        checkOutput("slow out_valid seen", (first >= 0), 1'b1);
        checkOutput("slow eng_start pulses", starts, 1);
        checkOutput("slow eng_x", eng_x, 8'h20);
        checkOutput("slow out_result", out_result, 16'h7F00);
        checkOutput("slow out_tag", out_tag, 8'h00);
        checkOutput("slow out_err", out_err, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1);
        checkOutput("slow eng_start after out", eng_start, 1'b0);

        $display("[TB] busy engine stalls START");
        applyStimulus(1'b0, 1'b1, 8'h44, 1'b1, 16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            checkOutput($sformatf("stall eng_start c%0d", k), eng_start, 1'b0);
            checkOutput($sformatf("stall busy c%0d", k), busy, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        checkOutput("stall eng_start released", eng_start, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        checkOutput("stall eng_start one cycle", eng_start, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h4444, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("stall out_valid", out_valid, 1'b1);
        checkOutput("stall out_result", out_result, 16'h4444);
        checkOutput("stall out_tag", out_tag, 8'h01);
        checkOutput("stall eng_x", eng_x, 8'h44);

        $display("[TB] back-to-back jobs with slow consumer");
        doReset();
        for (int j = 0; j < 3; j++) begin
            jres = {8'hA0, 8'(j)};
            applyStimulus(1'b0, 1'b1, 8'(j + 1), 1'b1, 16'h0000, 1'b0);
            checkOutput($sformatf("b2b j%0d accept in_ready", j), in_ready, 1'b1);
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b0);
            checkOutput($sformatf("b2b j%0d eng_start", j), eng_start, 1'b1);
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, jres, 1'b0);
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 16'h0000, 1'b0);
                checkOutput($sformatf("b2b j%0d hold%0d in_ready", j, k), in_ready, 1'b0);
                checkOutput($sformatf("b2b j%0d hold%0d out_valid", j, k), out_valid, 1'b1);
                checkOutput($sformatf("b2b j%0d hold%0d out_tag", j, k), out_tag, 8'(j));
                checkOutput($sformatf("b2b j%0d hold%0d out_result", j, k), out_result, jres);
            end
            applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("b2b j%0d release in_ready", j), in_ready, 1'b0);
            checkOutput($sformatf("b2b j%0d eng_x", j), eng_x, 8'(j + 1));
        end

        $display("[TB] engine never completes");
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0);
        checkOutput("wd eng_start", eng_start, 1'b1);
        first = -1;
        for (int c = 0; c < 100 && first < 0; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h5555, 1'b0);
            if (out_valid) first = c;
        end
`ifdef COS_TIMEOUT_EN
        checkOutput("wd out_valid cycle", first, 64);
        checkOutput("wd out_err", out_err, 1'b1);
        checkOutput("wd out_result", out_result, 16'h0000);
        checkOutput("wd out_tag", out_tag, 8'h03);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("wd back to idle", busy, 1'b0);
`else
        checkOutput("nowd out_valid never", first, -1);
        checkOutput("nowd busy", busy, 1'b1);
        checkOutput("nowd out_err", out_err, 1'b0);
        checkOutput("nowd out_result kept", out_result, 16'hA002);
        doReset();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("nowd reset busy", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
